// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
// Shared definitions for the MIPS core. The instruction decoder and the
// HI/LO multiply/divide sequencer both import this package.
//   alu_op_e     : ALU-op codes emitted by the decoder (5 bits)
//   md_state_e   : multiply/divide sequencer states
//   MD_LAST_ITER : counter value of the final shift-add/subtract iteration
//   mag32()      : magnitude of a 32-bit operand, taken only for signed ops
package mips_cpu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_MULT  = 5'd2,
    ALU_DIV   = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SRL   = 5'd11,
    ALU_SRA   = 5'd12,
    ALU_LUI   = 5'd13,
    ALU_MULTU = 5'd22,
    ALU_DIVU  = 5'd23,
    ALU_MTHI  = 5'd24,
    ALU_MTLO  = 5'd25
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  localparam logic [4:0] MD_LAST_ITER = 5'd31;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      mag32 = ~v + 32'd1;
    end else begin
      mag32 = v;
    end
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_seq_if.sv
// mips_cpu_muldiv_seq_if
// Command/result bundle between the core and the HI/LO multiply/divide
// sequencer.
//   start  : command valid, sampled each rising edge
//   op     : ALU-op code (MULT, MULTU, DIV, DIVU, MTHI, MTLO; others ignored)
//   rs_val : operand A (multiplicand / dividend / MT source)
//   rt_val : operand B (multiplier / divisor)
//   busy   : operation in flight, core stalls MFHI/MFLO
//   done   : one-cycle pulse when HI/LO were just written by mult/div
//   hi, lo : architectural HI and LO
// master = core side, slave = sequencer side.
interface mips_cpu_muldiv_seq_if;
  logic        start;
  logic [4:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, done, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_divstep.sv
// mips_cpu_divstep
// One radix-2 restoring-divide iteration, purely combinational.
//   rq      : {remainder, dividend/quotient} pair before the step
//   divisor : 32-bit divisor magnitude
//   rq_nxt  : pair after the step; the new quotient bit enters at bit 0
module mips_cpu_divstep (
  input  logic [63:0] rq,
  input  logic [31:0] divisor,
  output logic [63:0] rq_nxt
);

  logic [32:0] top_s;
  logic [32:0] diff_s;

  // Trial subtract of the divisor from the shifted partial remainder.
  always_comb begin
    top_s  = rq[63:31];
    diff_s = top_s - {1'b0, divisor};
    // Bit 32 of the difference is the borrow: set means restore.
    if (!diff_s[32]) begin
      rq_nxt = {diff_s[31:0], rq[30:0], 1'b1};
    end else begin
      rq_nxt = {top_s[31:0], rq[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq
// Iterative multiply/divide sequencer owning architectural HI/LO.
// MULT/MULTU/DIV/DIVU run 32 shift-add / restoring-divide iterations on
// operand magnitudes, then a FIX cycle applies signs and commits HI/LO.
// MTHI/MTLO write their register at the start edge and abort any op in flight.
//   clk     : core clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mips_cpu_muldiv_seq_if slave modport (start/op/operands in,
//             busy/done/hi/lo out, all outputs registered)
module mips_cpu_muldiv_seq
  import mips_cpu_pkg::*;
(
  input logic                  clk,
  input logic                  reset_n,
  mips_cpu_muldiv_seq_if.slave bus
);

  md_state_e   state_r, state_nxt_s;
  logic        busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic        is_mul_s, is_div_s, is_sgn_s, is_md_s, is_mt_s;
  logic        step_s, commit_s;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;          // mult: {partial product, multiplier}; div: {rem, quo}
  logic [31:0] mcand_r;        // multiplicand or divisor magnitude
  logic [31:0] araw_r;         // unmodified rs_val, the divide-by-zero HI value
  logic        div_op_r, neg_q_r, neg_r_r, divz_r;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_nxt_s, div_nxt_s, prod_s;
  logic [31:0] quo_s, rem_s, res_hi_s, res_lo_s, hi_r, lo_r;

  // Command decode; unknown op codes never count as a command.
  always_comb begin
    is_mul_s = (bus.op == ALU_MULT) || (bus.op == ALU_MULTU);
    is_div_s = (bus.op == ALU_DIV)  || (bus.op == ALU_DIVU);
    is_sgn_s = (bus.op == ALU_MULT) || (bus.op == ALU_DIV);
    is_md_s  = bus.start && (is_mul_s || is_div_s);
    is_mt_s  = bus.start && ((bus.op == ALU_MTHI) || (bus.op == ALU_MTLO));
  end

  // Next-state, step/commit strobes and next busy/done.
  always_comb begin
    state_nxt_s = state_r;
    step_s      = 1'b0;
    commit_s    = 1'b0;
    if (is_md_s) begin
      state_nxt_s = ST_RUN;                  // new op (re)starts from counter 0
    end else if (is_mt_s) begin
      state_nxt_s = ST_IDLE;                 // MT aborts anything in flight
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_RUN: begin
          step_s      = 1'b1;
          state_nxt_s = (cnt_r == MD_LAST_ITER) ? ST_FIX : ST_RUN;
        end
        ST_FIX: begin
          commit_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = commit_s;
  end

  // State register with registered busy/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Inline multiply step: conditional add into the upper half, then shift right.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mcand_r} : 33'd0);
    mul_nxt_s = {mul_sum_s, acc_r[31:1]};
  end

  mips_cpu_divstep u_divstep (
    .rq      (acc_r),
    .divisor (mcand_r),
    .rq_nxt  (div_nxt_s)
  );

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= 5'd0;
      acc_r    <= 64'd0;
      mcand_r  <= 32'd0;
      araw_r   <= 32'd0;
      div_op_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      divz_r   <= 1'b0;
    end else if (is_md_s) begin
      cnt_r    <= 5'd0;
      acc_r    <= {32'd0, is_div_s ? mag32(bus.rs_val, is_sgn_s) : mag32(bus.rt_val, is_sgn_s)};
      mcand_r  <= is_div_s ? mag32(bus.rt_val, is_sgn_s) : mag32(bus.rs_val, is_sgn_s);
      araw_r   <= bus.rs_val;
      div_op_r <= is_div_s;
      neg_q_r  <= is_sgn_s && (bus.rs_val[31] ^ bus.rt_val[31]);
      neg_r_r  <= is_sgn_s && bus.rs_val[31];
      divz_r   <= is_div_s && (bus.rt_val == 32'd0);
    end else if (step_s) begin
      cnt_r    <= cnt_r + 5'd1;
      acc_r    <= div_op_r ? div_nxt_s : mul_nxt_s;
    end
  end

  // FIX-cycle sign correction and divide-by-zero override.
  always_comb begin
    prod_s = neg_q_r ? (~acc_r + 64'd1) : acc_r;
    quo_s  = neg_q_r ? (~acc_r[31:0] + 32'd1) : acc_r[31:0];
    rem_s  = neg_r_r ? (~acc_r[63:32] + 32'd1) : acc_r[63:32];
    if (!div_op_r) begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end else if (divz_r) begin
      res_hi_s = araw_r;
      res_lo_s = 32'hFFFF_FFFF;
    end else begin
      res_hi_s = rem_s;
      res_lo_s = quo_s;
    end
  end

  // Architectural HI/LO: written only by MTHI/MTLO or a FIX commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (is_mt_s) begin
      if (bus.op == ALU_MTHI) begin
        hi_r <= bus.rs_val;
      end else begin
        lo_r <= bus.rs_val;
      end
    end else if (commit_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
